id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus the EX-stage operand network that feeds the right shifter and the ALU.
- Latches decoded fields and register-file reads from ID, then applies EX/MEM and MEM/WB forwarding.
- Produces the shifter's data operand, its 5-bit shift amount and its zero-force (reset) control.
- Supports hold (EX freeze) and flush (bubble insert).

---
 rtl/id_ex_operand_stage.sv | 156 +++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding feeding the right shifter and ALU.
// Optional macro SHIFT_VAR_EN: when defined, SRLV takes its shift amount from the forwarded rs[4:0].
module id_ex_operand_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [4:0]    id_shamt,
  input  logic          id_is_shift,
  input  logic          id_shift_var,
  input  logic [5:0]    id_op,
  input  logic          id_reg_write,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          ex_valid,
  output logic [DW-1:0] ex_alu_a,
  output logic [DW-1:0] ex_alu_b,
  output logic [DW-1:0] ex_shift_data,
  output logic [4:0]    ex_shamt,
  output logic          ex_shift_kill,
  output logic [5:0]    ex_op,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write
);

  logic          valid_q;
  logic [RW-1:0] rs_addr_q;
  logic [RW-1:0] rt_addr_q;
  logic [RW-1:0] rd_addr_q;
  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rt_data_q;
  logic [DW-1:0] imm_q;
  logic          use_imm_q;
  logic [4:0]    shamt_q;
  logic          is_shift_q;
  logic [5:0]    op_q;
  logic          reg_write_q;

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // Operand forwarding: youngest producer wins, r0 is hardwired zero
  always_comb begin
    fwd_rs = rs_data_q;
    if (rs_addr_q == '0) begin
      fwd_rs = '0;
    end else if (exmem_reg_write && (exmem_rd == rs_addr_q)) begin
      fwd_rs = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == rs_addr_q)) begin
      fwd_rs = memwb_result;
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (rt_addr_q == '0) begin
      fwd_rt = '0;
    end else if (exmem_reg_write && (exmem_rd == rt_addr_q)) begin
      fwd_rt = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == rt_addr_q)) begin
      fwd_rt = memwb_result;
    end
  end

  // Pipeline register; during hold the operand data tracks forwarding so it survives producer retirement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      shamt_q     <= '0;
      is_shift_q  <= 1'b0;
      op_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (flush || (!hold && !id_valid)) begin
      valid_q     <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      shamt_q     <= '0;
      is_shift_q  <= 1'b0;
      op_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (hold) begin
      rs_data_q   <= fwd_rs;
      rt_data_q   <= fwd_rt;
    end else begin
      valid_q     <= 1'b1;
      rs_addr_q   <= id_rs_addr;
      rt_addr_q   <= id_rt_addr;
      rd_addr_q   <= id_rd_addr;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      use_imm_q   <= id_use_imm;
      shamt_q     <= id_shamt;
      is_shift_q  <= id_is_shift;
      op_q        <= id_op;
      reg_write_q <= id_reg_write;
    end
  end

`ifdef SHIFT_VAR_EN
  logic shift_var_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_var_q <= 1'b0;
    end else if (flush || (!hold && !id_valid)) begin
      shift_var_q <= 1'b0;
    end else if (!hold) begin
      shift_var_q <= id_shift_var;
    end
  end

  assign ex_shamt = shift_var_q ? fwd_rs[4:0] : shamt_q;
`else
  logic unused_shift_var;
  assign unused_shift_var = id_shift_var;
  assign ex_shamt         = shamt_q;
`endif

  assign ex_valid      = valid_q;
  assign ex_alu_a      = fwd_rs;
  assign ex_alu_b      = use_imm_q ? imm_q : fwd_rt;
  assign ex_shift_data = fwd_rt;
  assign ex_shift_kill = ~valid_q | ~is_shift_q;
  assign ex_op         = op_q;
  assign ex_rd         = rd_addr_q;
  assign ex_reg_write  = reg_write_q & valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage; expectations follow SHIFT_VAR_EN like the design.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        hold;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic [4:0]  id_rd_addr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic        id_use_imm;
  logic [4:0]  id_shamt;
  logic        id_is_shift;
  logic        id_shift_var;
  logic [5:0]  id_op;
  logic        id_reg_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        ex_valid;
  logic [31:0] ex_alu_a;
  logic [31:0] ex_alu_b;
  logic [31:0] ex_shift_data;
  logic [4:0]  ex_shamt;
  logic        ex_shift_kill;
  logic [5:0]  ex_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;

  int checks;
  int errors;

  id_ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rd_addr(id_rd_addr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_shamt(id_shamt),
    .id_is_shift(id_is_shift), .id_shift_var(id_shift_var), .id_op(id_op),
    .id_reg_write(id_reg_write), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result), .ex_valid(ex_valid), .ex_alu_a(ex_alu_a),
    .ex_alu_b(ex_alu_b), .ex_shift_data(ex_shift_data), .ex_shamt(ex_shamt),
    .ex_shift_kill(ex_shift_kill), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid     = 1'b0;
    id_rs_addr   = '0;
    id_rt_addr   = '0;
    id_rd_addr   = '0;
    id_rs_data   = '0;
    id_rt_data   = '0;
    id_imm       = '0;
    id_use_imm   = 1'b0;
    id_shamt     = '0;
    id_is_shift  = 1'b0;
    id_shift_var = 1'b0;
    id_op        = '0;
    id_reg_write = 1'b0;
  endtask

  logic [31:0] exp_shamt;

  initial begin
    checks = 0;
    errors = 0;
    hold = 1'b0;
    flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    // Arbitrary inputs while reset is asserted
    reset = 1'b1;
    clear_id();
    id_valid = 1'b1; id_is_shift = 1'b1; id_rt_addr = 5'd7; id_rt_data = 32'hDEAD_BEEF;
    id_reg_write = 1'b1; id_rd_addr = 5'd9; id_op = 6'h2A; id_shamt = 5'd9;
    #2;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_kill", 32'(ex_shift_kill), 32'd1);
    check("rst_shdata", ex_shift_data, 32'h0);
    check("rst_regwr", 32'(ex_reg_write), 32'd0);
    check("rst_rd", 32'(ex_rd), 32'd0);
    tick();
    check("rst_hold_valid", 32'(ex_valid), 32'd0);
    reset = 1'b0;

    // SRL rt=r7 0xF000_0000 shamt 4
    clear_id();
    id_valid = 1'b1; id_is_shift = 1'b1; id_rt_addr = 5'd7; id_rt_data = 32'hF000_0000;
    id_shamt = 5'd4; id_reg_write = 1'b1; id_rd_addr = 5'd9; id_op = 6'h02;
    tick();
    check("srl_shdata", ex_shift_data, 32'hF000_0000);
    check("srl_shamt", 32'(ex_shamt), 32'd4);
    check("srl_kill", 32'(ex_shift_kill), 32'd0);
    check("srl_valid", 32'(ex_valid), 32'd1);
    check("srl_rd", 32'(ex_rd), 32'd9);
    check("srl_op", 32'(ex_op), 32'h02);
    check("srl_regwr", 32'(ex_reg_write), 32'd1);

    // Asynchronous reset in mid-cycle discards the EX instruction
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_kill", 32'(ex_shift_kill), 32'd1);
    check("arst_shdata", ex_shift_data, 32'h0);
    reset = 1'b0;

    // Forwarding priority on rt=r3
    id_rt_addr = 5'd3; id_rt_data = 32'h0000_0042;
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h8000_0001;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h0000_1234;
    #1;
    check("fwd_exmem", ex_shift_data, 32'h8000_0001);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb", ex_shift_data, 32'h0000_1234);
    memwb_reg_write = 1'b0;
    #1;
    check("fwd_none", ex_shift_data, 32'h0000_0042);

    // r0 never forwards; immediate selects ALU B
    clear_id();
    id_valid = 1'b1; id_rs_addr = 5'd0; id_rs_data = 32'h0000_0055;
    id_rt_addr = 5'd4; id_rt_data = 32'h0000_0777;
    id_imm = 32'h1234_ABCD; id_use_imm = 1'b1; id_op = 6'h21;
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFFFF_FFFF;
    #1;
    check("r0_alu_a", ex_alu_a, 32'h0);
    check("imm_alu_b", ex_alu_b, 32'h1234_ABCD);
    check("nonshift_kill", 32'(ex_shift_kill), 32'd1);
    exmem_rd = 5'd4;
    #1;
    check("fwd_rt_shdata", ex_shift_data, 32'hFFFF_FFFF);
    exmem_reg_write = 1'b0;

    // Hold while MEM/WB produces rt, then retires
    clear_id();
    id_valid = 1'b1; id_is_shift = 1'b1; id_rt_addr = 5'd5; id_rt_data = 32'h0;
    id_reg_write = 1'b1; id_rd_addr = 5'd10; id_shamt = 5'd1;
    tick();
    id_rt_data = 32'h0000_1111; id_rd_addr = 5'd11; id_shamt = 5'd2;
    hold = 1'b1;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hAAAA_5555;
    #1;
    check("hold_c1_shdata", ex_shift_data, 32'hAAAA_5555);
    tick();
    memwb_reg_write = 1'b0;
    #1;
    check("hold_c2_shdata", ex_shift_data, 32'hAAAA_5555);
    check("hold_rd", 32'(ex_rd), 32'd10);
    check("hold_shamt", 32'(ex_shamt), 32'd1);
    tick();
    hold = 1'b0;
    #1;
    check("hold_rel_shdata", ex_shift_data, 32'hAAAA_5555);

    // hold and flush together: flush wins
    hold = 1'b1; flush = 1'b1;
    tick();
    check("hf_valid", 32'(ex_valid), 32'd0);
    check("hf_regwr", 32'(ex_reg_write), 32'd0);
    check("hf_kill", 32'(ex_shift_kill), 32'd1);
    hold = 1'b0; flush = 1'b0;

    // SRLV: shift amount from forwarded rs[4:0] when the feature is built in
    clear_id();
    id_valid = 1'b1; id_is_shift = 1'b1; id_shift_var = 1'b1;
    id_rs_addr = 5'd2; id_rs_data = 32'h0000_0123;
    id_rt_addr = 5'd1; id_rt_data = 32'h0000_FFFF; id_shamt = 5'd7;
    tick();
`ifdef SHIFT_VAR_EN
    exp_shamt = 32'd3;
`else
    exp_shamt = 32'd7;
`endif
    check("srlv_shamt", 32'(ex_shamt), exp_shamt);
    check("srlv_shdata", ex_shift_data, 32'h0000_FFFF);

    // Invalid ID instruction loads a bubble
    clear_id();
    id_reg_write = 1'b1; id_is_shift = 1'b1; id_rd_addr = 5'd12;
    tick();
    check("bub_regwr", 32'(ex_reg_write), 32'd0);
    check("bub_kill", 32'(ex_shift_kill), 32'd1);
    check("bub_valid", 32'(ex_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
